rate_mult_rx: RTL and testbench

// - Receive end of the binary-rate-multiplier pulse link: recovers control word C from the serial pulse stream Z.
// - Keeps a phase counter in lock-step with the transmitter's counter, classifies each enabled cycle into a slot,
//   and rebuilds one C bit per slot over a 2^WIDTH frame.
// - Sits between the pulse link and the control/monitor logic; reports word, pulse count and link errors per frame.

---
 rtl/rm_pkg.sv | 24 ++
 rtl/rate_mult_rx_if.sv | 24 ++
 rtl/rm_slot_decode.sv | 16 +
 rtl/rate_mult_rx.sv | 132 +++++++++++++
 tb/tb_rate_mult_rx.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/rm_pkg.sv
// Shared definitions for the binary-rate-multiplier link (transmitter and receiver).
// Slot numbering is the trailing-ones count of the phase counter; all-ones is the idle slot.
package rm_pkg;

    localparam int WIDTH     = 8;
    localparam int SLOT_W    = $clog2(WIDTH + 1);
    localparam int IDLE_SLOT = WIDTH;

    // Counts consecutive ones from bit 0 upward, looking at the low `width` bits only.
    function automatic int trailing_ones(input logic [31:0] cnt, input int width);
        int  n;
        logic stop;
        n    = 0;
        stop = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (i < width && !stop) begin
                if (cnt[i]) n++;
                else        stop = 1'b1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/rate_mult_rx_if.sv
// Pulse-link input and frame-result handshake bundle for the rate-multiplier receiver.
interface rate_mult_rx_if #(parameter int WIDTH = rm_pkg::WIDTH);

    logic             en;
    logic             sync_in;
    logic             z_in;
    logic             out_ready;
    logic [WIDTH-1:0] c_out;
    logic [WIDTH-1:0] pulse_count;
    logic             err;
    logic             overrun;
    logic             out_valid;

    modport master (
        output en, sync_in, z_in, out_ready,
        input  c_out, pulse_count, err, overrun, out_valid
    );

    modport slave (
        input  en, sync_in, z_in, out_ready,
        output c_out, pulse_count, err, overrun, out_valid
    );

endinterface

// File: rtl/rm_slot_decode.sv
// Combinational phase-counter decode: slot index (trailing ones) and idle flag (all ones).
module rm_slot_decode
    import rm_pkg::*;
#(
    parameter int WIDTH = rm_pkg::WIDTH,
    localparam int SW   = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] cnt_i,
    output logic [SW-1:0]    slot_o,
    output logic             idle_o
);

    assign slot_o = SW'(trailing_ones(32'(cnt_i), WIDTH));
    assign idle_o = &cnt_i;

endmodule

// File: rtl/rate_mult_rx.sv
// Receive side of the rate-multiplier link: tracks the transmitter phase, rebuilds C one
// bit per slot over a 2^WIDTH frame, and hands each frame result out through valid/ready.
module rate_mult_rx
    import rm_pkg::*;
#(
    parameter int WIDTH = rm_pkg::WIDTH,
    localparam int SW   = $clog2(WIDTH + 1)
) (
    input  logic         clk,
    input  logic         rst,
    rate_mult_rx_if.slave bus
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] seen_q, seen_d;
    logic [WIDTH-1:0] pulses_q, pulses_d;
    logic             ferr_q, ferr_d;

    logic [WIDTH-1:0] c_out_q, c_out_d;
    logic [WIDTH-1:0] pcount_q, pcount_d;
    logic             err_q, err_d;
    logic             overrun_q, overrun_d;
    logic             valid_q, valid_d;

    logic [SW-1:0]    slot;
    logic             idle;
    logic [WIDTH-1:0] slot_oh;
    logic             cur_acc;
    logic             cur_seen;
    logic             samp_err;
    logic [WIDTH-1:0] pulses_nxt;

    rm_slot_decode #(.WIDTH(WIDTH)) u_decode (
        .cnt_i  (cnt_q),
        .slot_o (slot),
        .idle_o (idle)
    );

    // The idle slot index equals WIDTH, so its one-hot mask shifts out to all zeros.
    assign slot_oh    = WIDTH'(1) << slot;
    assign cur_acc    = |(acc_q & slot_oh);
    assign cur_seen   = |(seen_q & slot_oh);
    assign pulses_nxt = pulses_q + WIDTH'(bus.z_in);

    always_comb begin
        // NOTE: every variable gets its hold value first so no path can infer a latch.
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        seen_d    = seen_q;
        pulses_d  = pulses_q;
        ferr_d    = ferr_q;
        c_out_d   = c_out_q;
        pcount_d  = pcount_q;
        err_d     = err_q;
        overrun_d = overrun_q;
        valid_d   = valid_q;
        samp_err  = 1'b0;

        if (valid_q && bus.out_ready) valid_d = 1'b0;

        if (bus.sync_in) begin
            cnt_d    = '0;
            acc_d    = '0;
            seen_d   = '0;
            pulses_d = '0;
            ferr_d   = 1'b0;
        end else if (bus.en) begin
            cnt_d = cnt_q + WIDTH'(1);

            if (idle) begin
                samp_err = bus.z_in;
            end else if (cur_seen) begin
                samp_err = (bus.z_in != cur_acc);
            end else begin
                acc_d  = bus.z_in ? (acc_q | slot_oh) : (acc_q & ~slot_oh);
                seen_d = seen_q | slot_oh;
            end

            if (idle) begin
                // A frame end that meets an unread, unaccepted result overwrites it.
                c_out_d  = acc_q;
                pcount_d = pulses_nxt;
                err_d    = ferr_q | samp_err;
                valid_d  = 1'b1;
                if (valid_q && !bus.out_ready) overrun_d = 1'b1;
                acc_d    = '0;
                seen_d   = '0;
                pulses_d = '0;
                ferr_d   = 1'b0;
            end else begin
                pulses_d = pulses_nxt;
                ferr_d   = ferr_q | samp_err;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: acc/seen are a few flops, not a RAM, so they take the async reset too.
            cnt_q     <= '0;
            acc_q     <= '0;
            seen_q    <= '0;
            pulses_q  <= '0;
            ferr_q    <= 1'b0;
            c_out_q   <= '0;
            pcount_q  <= '0;
            err_q     <= 1'b0;
            overrun_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking here so every register samples the same pre-edge values.
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            seen_q    <= seen_d;
            pulses_q  <= pulses_d;
            ferr_q    <= ferr_d;
            c_out_q   <= c_out_d;
            pcount_q  <= pcount_d;
            err_q     <= err_d;
            overrun_q <= overrun_d;
            valid_q   <= valid_d;
        end
    end

    assign bus.c_out       = c_out_q;
    assign bus.pulse_count = pcount_q;
    assign bus.err         = err_q;
    assign bus.overrun     = overrun_q;
    assign bus.out_valid   = valid_q;

endmodule

// File: tb/tb_rate_mult_rx.sv
// Directed bench for rate_mult_rx at WIDTH=4 (16-cycle frame) with hand-computed expectations.
module tb_rate_mult_rx;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   tx_cnt;

    rate_mult_rx_if #(.WIDTH(4)) bus ();

    rate_mult_rx #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transmitter-side view of the slot map: z = C[trailing ones of cnt], nothing in the idle slot.
    function automatic logic z_of(input logic [3:0] c, input int cnt);
        int s;
        s = 0;
        while (s < 4 && cnt[s]) s++;
        if (s == 4) return 1'b0;
        return c[s];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one clock's inputs just after an edge, then step to 1 time unit past the next edge.
    task automatic cyc(input logic e, input logic z, input logic s, input logic r);
        bus.en        = e;
        bus.z_in      = z;
        bus.sync_in   = s;
        bus.out_ready = r;
        @(posedge clk);
        #1;
        if (s)      tx_cnt = 0;
        else if (e) tx_cnt = (tx_cnt + 1) % 16;
    endtask

    task automatic run_n(input logic [3:0] c, input int n, input logic r);
        for (int i = 0; i < n; i++) cyc(1'b1, z_of(c, tx_cnt), 1'b0, r);
    endtask

    task automatic check_frame(input string tag, input logic [3:0] c, input logic [3:0] pc,
                               input logic e, input logic ovr);
        check({tag, " out_valid"},   32'(bus.out_valid),   32'd1);
        check({tag, " c_out"},       32'(bus.c_out),       32'(c));
        check({tag, " pulse_count"}, 32'(bus.pulse_count), 32'(pc));
        check({tag, " err"},         32'(bus.err),         32'(e));
        check({tag, " overrun"},     32'(bus.overrun),     32'(ovr));
    endtask

    task automatic accept(input string tag);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check({tag, " accept clears out_valid"}, 32'(bus.out_valid), 32'd0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " c_out"},       32'(bus.c_out),       32'd0);
        check({tag, " pulse_count"}, 32'(bus.pulse_count), 32'd0);
        check({tag, " err"},         32'(bus.err),         32'd0);
        check({tag, " overrun"},     32'(bus.overrun),     32'd0);
        check({tag, " out_valid"},   32'(bus.out_valid),   32'd0);
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        tx_cnt        = 0;
        rst           = 1'b1;
        bus.en        = 1'b0;
        bus.z_in      = 1'b0;
        bus.sync_in   = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;

        // C=1010: slot1 x4 + slot3 x1 -> 5 pulses; result appears one cycle after cnt=15.
        run_n(4'b1010, 15, 1'b0);
        check("c1010 no valid before idle", 32'(bus.out_valid), 32'd0);
        run_n(4'b1010, 1, 1'b0);
        check_frame("c1010", 4'b1010, 4'd5, 1'b0, 1'b0);
        accept("c1010");

        // C=0110 plus a pulse in the idle slot: 4+2+1 = 7 pulses, error.
        run_n(4'b0110, 15, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        check_frame("idle pulse", 4'b0110, 4'd7, 1'b1, 1'b0);
        accept("idle pulse");

        // Slot0 first seen as 1 at cnt=0, later 0 -> bit kept, error.
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        run_n(4'b0000, 15, 1'b0);
        check_frame("slot0 mismatch", 4'b0001, 4'd1, 1'b1, 1'b0);
        accept("slot0 mismatch");

        // Two frames with nobody accepting: second overwrites first, overrun sticks.
        run_n(4'b0011, 16, 1'b0);
        check_frame("ovr first", 4'b0011, 4'd12, 1'b0, 1'b0);
        run_n(4'b0101, 16, 1'b0);
        check_frame("ovr second", 4'b0101, 4'd10, 1'b0, 1'b1);
        accept("ovr");
        check("overrun sticky after accept", 32'(bus.overrun), 32'd1);

        // en toggling: z driven high on en=0 cycles must be ignored; frame takes 32 clocks.
        for (int i = 0; i < 15; i++) begin
            cyc(1'b1, z_of(4'b1111, tx_cnt), 1'b0, 1'b0);
            cyc(1'b0, 1'b1, 1'b0, 1'b0);
        end
        check("toggle no valid before idle", 32'(bus.out_valid), 32'd0);
        cyc(1'b1, z_of(4'b1111, tx_cnt), 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        check_frame("en toggle", 4'b1111, 4'd15, 1'b0, 1'b1);
        accept("en toggle");

        // sync at cnt=6 discards the partial frame; result registers keep the old frame.
        run_n(4'b1111, 6, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        check("sync no valid", 32'(bus.out_valid), 32'd0);
        check("sync keeps c_out", 32'(bus.c_out), 32'hf);
        run_n(4'b0011, 15, 1'b0);
        check("post-sync no early valid", 32'(bus.out_valid), 32'd0);
        run_n(4'b0011, 1, 1'b0);
        check_frame("post-sync", 4'b0011, 4'd12, 1'b0, 1'b1);

        // Accept and frame end on the same edge: new frame loads, valid stays, no new overrun cause.
        run_n(4'b1100, 15, 1'b0);
        run_n(4'b1100, 1, 1'b1);
        check_frame("accept+end", 4'b1100, 4'd3, 1'b0, 1'b1);
        accept("accept+end");

        // Async reset at cnt=9 zeroes everything mid-cycle, including sticky overrun.
        run_n(4'b1111, 9, 1'b0);
        rst = 1'b1;
        #2;
        check_zero("mid-frame rst");
        @(posedge clk);
        #1;
        rst    = 1'b0;
        tx_cnt = 0;
        run_n(4'b1001, 15, 1'b0);
        check("post-rst no early valid", 32'(bus.out_valid), 32'd0);
        run_n(4'b1001, 1, 1'b0);
        check_frame("post-rst", 4'b1001, 4'd9, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
